// File: rtl/seg_pkg.sv
// ============================================================================
//  seg_pkg : shared types and default constants for the seven-segment path
//  Revision: 1.0
// ============================================================================
`default_nettype none

package seg_pkg;

  typedef enum logic [0:0] {
    DRIVE = 1'b0,
    BLANK = 1'b1
  } seg_state_e;

  localparam int unsigned SEG_NUM_DIGITS   = 2;
  localparam int unsigned SEG_DWELL_CYCLES = 24000;
  localparam int unsigned SEG_BLANK_CYCLES = 480;

  typedef logic [3:0] nibble_t;

  // Counter width wide enough for the longer of the two intervals.
  function automatic int unsigned seg_cnt_width(input int unsigned a, input int unsigned b);
    int unsigned m;
    m = (a > b) ? a : b;
    return (m < 2) ? 1 : $clog2(m);
  endfunction

endpackage

`default_nettype wire

// File: rtl/seg_tick_counter.sv
// ============================================================================
//  seg_tick_counter : up-counter with runtime terminal value; wraps to zero
//  and raises tc_o on the terminal count.  Revision: 1.0
// ============================================================================
`default_nettype none

module seg_tick_counter #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] term_i,
  output logic             tc_o
);

  logic [WIDTH-1:0] cnt_q;
  logic [WIDTH-1:0] cnt_d;

  always_comb begin
    tc_o  = (cnt_q == term_i);
    cnt_d = tc_o ? '0 : cnt_q + WIDTH'(1);
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

`default_nettype wire

// File: rtl/seg_digit_mux.sv
// ============================================================================
//  seg_digit_mux : time-multiplexes NUM_DIGITS hex nibbles onto one decoder
//  with active-low anodes; SEG_DIGIT_MUX_BLANK_EN adds an all-off gap.
//  Revision: 1.0
// ============================================================================
`default_nettype none

module seg_digit_mux
  import seg_pkg::*;
#(
  parameter int unsigned NUM_DIGITS   = SEG_NUM_DIGITS,
  parameter int unsigned DWELL_CYCLES = SEG_DWELL_CYCLES,
  parameter int unsigned BLANK_CYCLES = SEG_BLANK_CYCLES
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [4*NUM_DIGITS-1:0]       digits_i,
  output logic [3:0]                    s_o,
  output logic [NUM_DIGITS-1:0]         an_o,
  output logic [$clog2(NUM_DIGITS)-1:0] digit_idx_o,
  output logic                          frame_o
);

  localparam int unsigned IDX_W = $clog2(NUM_DIGITS);
  localparam int unsigned CNT_W = seg_cnt_width(DWELL_CYCLES, BLANK_CYCLES);
  localparam logic [CNT_W-1:0] DWELL_TERM = CNT_W'(DWELL_CYCLES - 1);
`ifdef SEG_DIGIT_MUX_BLANK_EN
  localparam bit               BLANK_EN   = 1'b1;
  localparam logic [CNT_W-1:0] BLANK_TERM = CNT_W'(BLANK_CYCLES - 1);
`else
  // BLANK only survives as the single post-reset cycle.
  localparam bit               BLANK_EN   = 1'b0;
  localparam logic [CNT_W-1:0] BLANK_TERM = '0;
`endif

  seg_state_e            state_q, state_d;
  logic [IDX_W-1:0]      idx_q, idx_d, idx_next;
  nibble_t               shadow_q [NUM_DIGITS];
  nibble_t               shadow_d [NUM_DIGITS];
  logic [3:0]            s_q, s_d;
  logic [NUM_DIGITS-1:0] an_q, an_d;
  logic [IDX_W-1:0]      didx_q, didx_d;
  logic                  frame_q, frame_d;
  logic [CNT_W-1:0]      term;
  logic                  tc;
  logic                  advance;

  assign term = (state_q == DRIVE) ? DWELL_TERM : BLANK_TERM;

  seg_tick_counter #(.WIDTH(CNT_W)) u_tick (
    .clk    (clk),
    .reset  (reset),
    .term_i (term),
    .tc_o   (tc)
  );

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    shadow_d = shadow_q;
    s_d      = s_q;
    an_d     = an_q;
    didx_d   = didx_q;
    frame_d  = 1'b0;
    advance  = 1'b0;
    idx_next = (idx_q == IDX_W'(NUM_DIGITS - 1)) ? '0 : idx_q + IDX_W'(1);

    if (tc) begin
      if (state_q == DRIVE && BLANK_EN) begin
        state_d = BLANK;
        an_d    = '1;
      end else begin
        advance = 1'b1;
      end
    end

    if (advance) begin
      state_d        = DRIVE;
      idx_d          = idx_next;
      didx_d         = idx_next;
      an_d           = '1;
      an_d[idx_next] = 1'b0;
      // Frame start: capture all digits and bypass digit 0 straight to s.
      if (idx_next == '0) begin
        for (int k = 0; k < NUM_DIGITS; k++) begin
          shadow_d[k] = digits_i[4*k +: 4];
        end
        s_d     = digits_i[3:0];
        frame_d = 1'b1;
      end else begin
        s_d = shadow_q[idx_next];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= BLANK;
      idx_q   <= IDX_W'(NUM_DIGITS - 1);
      for (int k = 0; k < NUM_DIGITS; k++) begin
        shadow_q[k] <= '0;
      end
      s_q     <= '0;
      an_q    <= '1;
      didx_q  <= '0;
      frame_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      shadow_q <= shadow_d;
      s_q      <= s_d;
      an_q     <= an_d;
      didx_q   <= didx_d;
      frame_q  <= frame_d;
    end
  end

  assign s_o         = s_q;
  assign an_o        = an_q;
  assign digit_idx_o = didx_q;
  assign frame_o     = frame_q;

endmodule

`default_nettype wire

// File: tb/tb_seg_digit_mux.sv
// ============================================================================
//  tb_seg_digit_mux : directed self-checking bench, 2 digits, dwell 4, blank 2
//  Revision: 1.0
// ============================================================================
`default_nettype none

module tb_seg_digit_mux;

  localparam int unsigned ND = 2;
`ifdef SEG_DIGIT_MUX_BLANK_EN
  localparam int D0_EDGE = 2;   // first edge driving digit 0
  localparam int SLOT    = 6;   // dwell + blank
`else
  localparam int D0_EDGE = 1;
  localparam int SLOT    = 4;
`endif
  localparam int FRAME = 2 * SLOT;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [7:0] digits = 8'h00;
  logic [3:0] s;
  logic [1:0] an;
  logic [0:0] didx;
  logic       frame;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  seg_digit_mux #(.NUM_DIGITS(ND), .DWELL_CYCLES(4), .BLANK_CYCLES(2)) dut (
    .clk         (clk),
    .reset       (reset),
    .digits_i    (digits),
    .s_o         (s),
    .an_o        (an),
    .digit_idx_o (didx),
    .frame_o     (frame)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b0; digits = 8'h3A;
    step(); step();
    checks++; if (an !== 2'b11) begin errors++; $display("FAIL reset_an got %b want 11", an); end
    checks++; if (s !== 4'h0) begin errors++; $display("FAIL reset_s got %h want 0", s); end
    checks++; if (frame !== 1'b0) begin errors++; $display("FAIL reset_frame got %b want 0", frame); end
    checks++; if (didx !== 1'b0) begin errors++; $display("FAIL reset_idx got %b want 0", didx); end
  endtask

  // Expects reset asserted on entry with digits_i = 8'h3A.
  task automatic test_startup();
    reset = 1'b1;
    if (D0_EDGE == 2) begin
      step();
      checks++; if (an !== 2'b11) begin errors++; $display("FAIL startup_blank_an got %b want 11", an); end
    end
    step();
    checks++; if (an !== 2'b10) begin errors++; $display("FAIL startup_an got %b want 10", an); end
    checks++; if (s !== 4'hA) begin errors++; $display("FAIL startup_s got %h want a", s); end
    checks++; if (frame !== 1'b1) begin errors++; $display("FAIL startup_frame got %b want 1", frame); end
    step();
    checks++; if (frame !== 1'b0) begin errors++; $display("FAIL startup_frame_pulse got %b want 0", frame); end
  endtask

  task automatic test_sequencing();
    logic [1:0] ean;
    logic [3:0] es;
    logic       eidx;
    int p;
    reset = 1'b0; digits = 8'h3A;
    step();
    reset = 1'b1;
    for (int e = 1; e <= 2 * FRAME + 1; e++) begin
      step();
      if (e < D0_EDGE) begin
        ean = 2'b11; es = 4'h0; eidx = 1'b0; p = -1;
      end else begin
        p = (e - D0_EDGE) % FRAME;
        if (p < 4)         begin ean = 2'b10; es = 4'hA; eidx = 1'b0; end
        else if (p < SLOT) begin ean = 2'b11; es = 4'hA; eidx = 1'b0; end
        else if (p < SLOT + 4) begin ean = 2'b01; es = 4'h3; eidx = 1'b1; end
        else               begin ean = 2'b11; es = 4'h3; eidx = 1'b1; end
      end
      checks++; if (an !== ean) begin errors++; $display("FAIL seq_an edge %0d got %b want %b", e, an, ean); end
      checks++; if (s !== es) begin errors++; $display("FAIL seq_s edge %0d got %h want %h", e, s, es); end
      checks++; if (didx !== eidx) begin errors++; $display("FAIL seq_idx edge %0d got %b want %b", e, didx, eidx); end
      checks++; if (frame !== (p == 0)) begin errors++; $display("FAIL seq_frame edge %0d got %b want %b", e, frame, (p == 0)); end
    end
  endtask

  task automatic test_coherency();
    reset = 1'b0; digits = 8'h3A;
    step();
    reset = 1'b1;
    for (int e = 1; e <= D0_EDGE + 3 * SLOT; e++) begin
      step();
      if (e == D0_EDGE + 1) digits = 8'h5C;
      if (e == D0_EDGE + SLOT) begin
        checks++; if (s !== 4'h3) begin errors++; $display("FAIL coh_old_d1 got %h want 3", s); end
      end
      if (e == D0_EDGE + 2 * SLOT) begin
        checks++; if (s !== 4'hC) begin errors++; $display("FAIL coh_new_d0 got %h want c", s); end
        checks++; if (frame !== 1'b1) begin errors++; $display("FAIL coh_frame got %b want 1", frame); end
      end
      if (e == D0_EDGE + 3 * SLOT) begin
        checks++; if (s !== 4'h5) begin errors++; $display("FAIL coh_new_d1 got %h want 5", s); end
      end
    end
  endtask

  task automatic test_reset_mid();
    int budget;
    digits = 8'h3A;
    budget = 0;
    while (an !== 2'b01 && budget < 50) begin
      step(); budget++;
    end
    checks++; if (an !== 2'b01) begin errors++; $display("FAIL mid_wait_d1 got %b want 01", an); end
    step();  // still mid-digit
    reset = 1'b0;
    step();
    checks++; if (an !== 2'b11) begin errors++; $display("FAIL mid_reset_an got %b want 11", an); end
    checks++; if (s !== 4'h0) begin errors++; $display("FAIL mid_reset_s got %h want 0", s); end
    test_startup();
  endtask

  task automatic test_anode_safety();
    logic pulsed;
    reset = 1'b1;
    for (int i = 0; i < 2000; i++) begin
      digits = 8'($urandom);
      pulsed = ($urandom_range(0, 49) == 0);
      reset = ~pulsed;
      step();
      checks++; if (an === 2'b00) begin errors++; $display("FAIL safety_two_low cycle %0d got %b", i, an); end
      if (pulsed) begin
        checks++; if (an !== 2'b11) begin errors++; $display("FAIL safety_reset_an cycle %0d got %b want 11", i, an); end
      end
    end
    reset = 1'b1;
  endtask

  initial begin
    test_reset();
    test_startup();
    test_sequencing();
    test_coherency();
    test_reset_mid();
    test_anode_safety();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/seg_digit_mux.md
# seg_digit_mux

Time-multiplexing stage directly upstream of `seg_display`. It drives the shared 4-bit hex nibble `s` into the decoder and drives the active-low common-anode enables for NUM_DIGITS digits, cycling through them at a fixed dwell rate. Digit values are captured once per frame so all digits in a frame come from one coherent sample. An optional blanking gap between digits suppresses ghosting.

## Interface
- NUM_DIGITS, 2, number of multiplexed digits; must be ≥2.
- DWELL_CYCLES, 24000, clk cycles each digit is driven; must be ≥2. The default gives 2 kHz per digit at 48 MHz.
- BLANK_CYCLES, 480, clk cycles with all anodes off between digits; must be ≥1. Used only when blanking is compiled in.
- clk, input, 1, system clock; all logic is on its rising edge.
- reset, input, 1, synchronous, active-low.
- digits_i, input, 4*NUM_DIGITS, nibble for digit k is at [4k+3:4k].
- s_o, output, 4, registered nibble to `seg_display` input `s`.
- an_o, output, NUM_DIGITS, registered anode enables, active-low; at most one bit is low at any time.
- digit_idx_o, output, $clog2(NUM_DIGITS), index of the digit currently selected.
- frame_o, output, 1, one-cycle pulse marking the start of each frame.

## Operation
- States: DRIVE and BLANK. State is held with a dwell counter cnt of width $clog2(max(DWELL_CYCLES, BLANK_CYCLES)) and a digit index idx.
- Reset values, applied at any edge where reset=0:
  - state=BLANK, cnt=0, idx=NUM_DIGITS-1, shadow=0.
  - an_o all 1s, s_o=0, digit_idx_o=0, frame_o=0.
- BLANK:
  - an_o is all 1s and s_o holds its last value.
  - At cnt==BLANK_CYCLES-1, go to DRIVE with idx=(idx+1) mod NUM_DIGITS and cnt=0.
- DRIVE:
  - an_o[idx]=0, all other bits are 1, and s_o=shadow[idx].
  - At cnt==DWELL_CYCLES-1, go to BLANK with cnt=0.
- Frame capture:
  - On the edge where idx wraps to 0, shadow is loaded from digits_i.
  - On that same edge, s_o takes digits_i[3:0] directly (bypass), and frame_o=1 for exactly one cycle.
  - Changes on digits_i between captures have no visible effect until the next frame.
- Reset mid-operation: reset=0 for one edge blanks all anodes on that edge and restarts from the reset state. No partial digit resumes.

## Timing
- All outputs are registered. There is no combinational path from digits_i to any output.
- Number the first rising edge with reset=1 as edge 1. Digit 0 is driven starting at edge BLANK_CYCLES, and frame_o is high for the following cycle.
- Each digit is driven for exactly DWELL_CYCLES cycles, followed by BLANK_CYCLES cycles of all-off.
- Frame period is NUM_DIGITS*(DWELL_CYCLES+BLANK_CYCLES).
- an_o never has two bits low in the same cycle, including across reset.
- A value applied to digits_i is visible on s_o no later than one frame period plus one cycle later.

## Configuration
- SEG_DIGIT_MUX_BLANK_EN defined:
  - BLANK is entered between every pair of digits, as described above.
- SEG_DIGIT_MUX_BLANK_EN undefined:
  - BLANK is entered only on exit from reset, for exactly one cycle. Digit 0 is driven from edge 1.
  - Digit switches go DRIVE→DRIVE on the same edge: one anode deasserts and the next asserts, with no all-off cycle.
  - Frame period is NUM_DIGITS*DWELL_CYCLES.
  - BLANK_CYCLES is ignored.

## Structure
- Shared package `seg_pkg` holds:
  - the state enum typedef (DRIVE, BLANK);
  - the default constants for NUM_DIGITS, DWELL_CYCLES and BLANK_CYCLES;
  - the nibble typedef (4 bits), shared with `seg_display`.
- One sub-module, `seg_tick_counter`: a resettable up-counter with a runtime terminal value and a terminal-count pulse, reused for both dwell and blank intervals.
- Top-level integration connects s_o to `seg_display` and an_o to the anode pins.

## Test plan
All scenarios use NUM_DIGITS=2, DWELL_CYCLES=4, BLANK_CYCLES=2, with blanking enabled unless noted.
- Startup: hold digits_i=8'h3A and release reset → an_o=2'b11 after edge 1, then 2'b10 with s_o=4'hA from edge 2, and frame_o high for exactly one cycle.
- Sequencing: an_o=2'b10 for 4 cycles, then 2'b11 for 2 cycles, then 2'b01 with s_o=4'h3 for 4 cycles, then 2'b11 for 2 cycles; frame period is 12 cycles.
- Coherency: change digits_i to 8'h5C while digit 0 is driven → digit 1 still shows 3 in that frame; the next frame shows C, then 5.
- Reset mid-digit: pulse reset=0 for one edge while an_o=2'b01 → an_o=2'b11 and s_o=0 on that edge, and the startup sequence repeats.
- Anode safety: run 2000 cycles with random digits_i and random single-cycle reset pulses → an_o is never 2'b00.
- SEG_DIGIT_MUX_BLANK_EN undefined: after startup, an_o alternates 2'b10/2'b01 every 4 cycles, never shows 2'b11, and the frame period is 8 cycles.
